simple_bus_mem_slave: RTL and testbench
=======================================

// Module: simple_bus_mem_slave
// PURPOSE
//  - Slave endpoint on the simple bus: a bus master issues read/write/burst requests and this block services them from a local memory.
//  - Implements the slave side of the handshake: req/gnt arbitration, start/rdy per beat, 8-bit addr, 2-bit mode, data.
//  - Sits directly downstream of the bus master and is the terminal consumer of bus transactions.
// PARAMETERS
//  - DATA_W       8   data width
//  - ADDR_W       8   address width; memory depth = 2**ADDR_W
//  - WAIT_STATES  1   extra cycles inserted before each rdy (0 allowed)
//  - BURST_LEN    4   beats per burst read (>=2)
// PORTS
//  - clk       in   1       bus clock; all logic rising-edge
//  - rst       in   1       asynchronous, active-high reset
//  - req       in   1       master requests bus ownership
//  - gnt       out  1       ownership granted to master
//  - start     in   1       one-cycle pulse: addr/mode/data_in valid
//  - addr      in   ADDR_W  beat-0 address
//  - mode      in   2       00 READ, 01 WRITE, 10 BURST_READ, 11 NOP
//  - data_in   in   DATA_W  write data from master
//  - data_out  out  DATA_W  read data
//  - data_oe   out  1       slave drives data (high only on read rdy beats)
//  - rdy       out  1       one-cycle pulse per completed beat
// BEHAVIOUR
//  - Reset (async, immediate): gnt=0, rdy=0, data_oe=0, data_out=0, state=IDLE, counters=0. Memory contents are not reset; they persist across reset.
//  - States: IDLE -> GRANT -> ACCESS -> (ACCESS per beat) -> GRANT or IDLE.
//  - IDLE: on req=1 at edge, go GRANT; gnt=1 from the next cycle.
//  - GRANT, gnt=1:
//    - start=1: latch addr, mode and data_in; go ACCESS; wait counter = WAIT_STATES.
//    - start=0 and req=0: go IDLE; gnt=0 next cycle.
//    - start=1 with req=0 in the same cycle: start wins; the transaction runs.
//  - start while gnt=0 or while in ACCESS: ignored.
//  - ACCESS: decrement the counter each cycle. At the edge where it reads 0:
//    - rdy=1 for exactly one cycle. rdy is first high WAIT_STATES+1 cycles after the start edge.
//    - READ: data_out=mem[addr_q] and data_oe=1 in that same cycle.
//    - WRITE: mem[addr_q]<=wdata_q at that edge; data_oe stays 0.
//    - NOP: rdy only; no memory effect; data_oe=0.
//  - BURST_READ: BURST_LEN beats, each WAIT_STATES+1 cycles, so BURST_LEN rdy pulses total.
//    - Address increments by 1 per beat and wraps modulo 2**ADDR_W (FF -> 00).
//  - After the last beat: req=1 -> GRANT, gnt stays 1. req=0 -> IDLE, gnt=0 next cycle.
//  - req deasserted during ACCESS: the current transaction (all burst beats) completes before release.
//  - data_out holds its last value when data_oe=0.
// CONFIGURATION
//  - Macro SIMPLE_BUS_MEM_SLAVE_BURST_EN
//    - Defined: mode 10 performs a BURST_LEN-beat read as above.
//    - Undefined: mode 10 is treated as a single READ (one rdy pulse); burst address counter logic is not compiled.
// STRUCTURE
//  - simple_bus_pkg holds:
//    - typedef enum logic [1:0] bus_mode_e {MODE_READ, MODE_WRITE, MODE_BURST_READ, MODE_NOP}
//    - typedef enum slave_state_e {S_IDLE, S_GRANT, S_ACCESS}
//    - localparam BURST_LEN_DEFAULT = 4
//  - One sub-module: simple_bus_mem_array. 2**ADDR_W x DATA_W register array, synchronous write, combinational read, no reset.
//  - FSM, wait counter and beat counter live in the top module.
// TESTING
//  - Reset: rst=1 mid-idle -> gnt=0, rdy=0, data_oe=0, data_out=0 asynchronously.
//  - WAIT_STATES=1: write A5 to 0x10, then read 0x10 -> each rdy exactly 2 cycles after its start; read beat has data_out=A5, data_oe=1.
//  - Burst wrap: write FE=11, FF=22, 00=33, 01=44, then burst read at FE.
//    - BURST_EN defined -> 4 rdy pulses with data 11, 22, 33, 44.
//    - BURST_EN undefined -> 1 pulse with data 11.
//  - Ownership: req=1 then req=0 with no start -> gnt falls next cycle; start while gnt=0 -> no rdy within 10 cycles.
//  - rst pulsed after 2nd burst beat -> rdy/gnt drop at once. After release, read FE and 01 -> 11 and 44 unchanged.
//  - NOP at 0x10 -> single rdy, data_oe=0; subsequent read 0x10 still A5.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types for the simple bus memory slave: bus modes, slave FSM states,
// and a small helper that classifies the modes that return data.
package simple_bus_pkg;

    typedef enum logic [1:0] {
        MODE_READ       = 2'b00,
        MODE_WRITE      = 2'b01,
        MODE_BURST_READ = 2'b10,
        MODE_NOP        = 2'b11
    } bus_mode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT  = 2'b01,
        S_ACCESS = 2'b10
    } slave_state_e;

    localparam int BURST_LEN_DEFAULT = 4;

    // A burst read still returns data on every beat, so it counts as a read.
    function automatic logic mode_is_read(input bus_mode_e m);
        return (m == MODE_READ) || (m == MODE_BURST_READ);
    endfunction

endpackage

// File: rtl/simple_bus_mem_array.sv
// Local storage for the bus slave: 2**ADDR_W x DATA_W registers with a
// synchronous write port and a combinational read port. Contents are never reset.
module simple_bus_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/simple_bus_mem_slave.sv
// Simple bus slave endpoint: grants the bus on req, then services READ, WRITE,
// BURST_READ and NOP beats from a local memory with WAIT_STATES per beat.
// Burst support is compiled in only when SIMPLE_BUS_MEM_SLAVE_BURST_EN is defined.
module simple_bus_mem_slave
    import simple_bus_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int BURST_LEN   = BURST_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              gnt,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              rdy
);

    localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    slave_state_e      state;
    logic [WAIT_W-1:0] wait_q;

    // Transaction attributes captured at the start edge
    logic [ADDR_W-1:0] addr_q;
    bus_mode_e         mode_q;
    logic [DATA_W-1:0] wdata_q;

    logic              start_acc;
    logic              beat_done;
    logic              last_beat;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign start_acc = (state == S_GRANT) && start;
    assign beat_done = (state == S_ACCESS) && (wait_q == '0);
    assign mem_we    = beat_done && (mode_q == MODE_WRITE);

`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [BEAT_W-1:0] beat_q;

    assign last_beat = (mode_q != MODE_BURST_READ) || (beat_q == LAST_BEAT);
`else
    // Without burst support every transaction is a single beat.
    wire [7:0] unused_burst_len = 8'(BURST_LEN);

    assign last_beat = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (start_acc) begin
            addr_q  <= addr;
            mode_q  <= bus_mode_e'(mode);
            wdata_q <= data_in;
        end
`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
        else if (beat_done && !last_beat) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= 1'b0;
            rdy      <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
            wait_q   <= '0;
`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
            beat_q   <= '0;
`endif
        end else begin
            rdy     <= 1'b0;
            data_oe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_GRANT;
                        gnt   <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // start takes priority over a simultaneous release
                    if (start) begin
                        state  <= S_ACCESS;
                        wait_q <= WAIT_INIT;
`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
                        beat_q <= '0;
`endif
                    end else if (!req) begin
                        state <= S_IDLE;
                        gnt   <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end else begin
                        rdy <= 1'b1;
                        if (mode_is_read(mode_q)) begin
                            data_out <= mem_rdata;
                            data_oe  <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= req ? S_GRANT : S_IDLE;
                            gnt   <= req;
                        end else begin
                            wait_q <= WAIT_INIT;
`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
                            beat_q <= beat_q + BEAT_W'(1);
`endif
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= 1'b0;
                end
            endcase
        end
    end

    simple_bus_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Randomized bench for simple_bus_mem_slave: a transaction-level timeline model
// predicts gnt/rdy/data_oe/data_out per cycle, plus literal directed checks.
module tb_simple_bus_mem_slave;

    localparam int WS   = 1;
    localparam int BL   = 4;
    localparam int MAXC = 16384;
`ifdef SIMPLE_BUS_MEM_SLAVE_BURST_EN
    localparam int BURST_EN = 1;
`else
    localparam int BURST_EN = 0;
`endif

    logic       clk;
    logic       rst;
    logic       req;
    logic       gnt;
    logic       start;
    logic [7:0] addr;
    logic [1:0] mode;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rdy;

    simple_bus_mem_slave #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .WAIT_STATES (WS),
        .BURST_LEN   (BL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .start    (start),
        .addr     (addr),
        .mode     (mode),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .rdy      (rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs after each rising edge, indexed by edge number
    bit         exp_gnt  [MAXC];
    bit         exp_rdy  [MAXC];
    bit         exp_oe   [MAXC];
    logic [7:0] exp_data [MAXC];
    logic [7:0] mem_m    [256];

    int         n_chk  = 0;
    int         n_fail = 0;
    bit         owned  = 0;
    bit         done   = 0;
    bit         chk_en = 0;
    bit         aborted = 0;
    int         last_s = 0;
    logic [7:0] held   = 8'h00;

    logic [7:0] rdy_d[$];
    int         rdy_c[$];
    bit         rdy_oe[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic mon();
        while (!done) begin
            @(negedge clk or posedge rst);
            if (rst) begin
                held = 8'h00;
            end else if (chk_en && cyc < MAXC) begin
                if (exp_oe[cyc]) held = exp_data[cyc];
                chk("gnt", 32'(gnt), 32'(exp_gnt[cyc]));
                chk("rdy", 32'(rdy), 32'(exp_rdy[cyc]));
                chk("data_oe", 32'(data_oe), 32'(exp_oe[cyc]));
                chk("data_out", 32'(data_out), 32'(held));
                if (rdy) begin
                    rdy_d.push_back(data_out);
                    rdy_c.push_back(cyc);
                    rdy_oe.push_back(data_oe);
                end
            end
        end
    endtask

    task automatic rdy_clear();
        rdy_d.delete();
        rdy_c.delete();
        rdy_oe.delete();
    endtask

    // Asynchronous reset pulse issued between clock edges
    task automatic do_reset();
        req   = 1'b0;
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        for (int k = cyc + 1; k < MAXC; k++) begin
            exp_gnt[k] = 1'b0;
            exp_rdy[k] = 1'b0;
            exp_oe[k]  = 1'b0;
        end
        tick();
        #2 rst = 1'b0;
        owned = 1'b0;
    endtask

    // n cycles without a transaction; outside ACCESS, gnt after an edge equals req at it
    task automatic hold(input logic rq, input int n, input logic st);
        repeat (n) begin
            req     = rq;
            start   = st && !owned;
            mode    = 2'($urandom);
            addr    = 8'($urandom);
            data_in = 8'($urandom);
            exp_gnt[cyc + 1] = rq;
            tick();
            owned = rq;
        end
    endtask

    task automatic xact(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                        input logic req_s, input logic req_a, input int abort_after);
        int s;
        int nb;
        int r;
        int last_edge;
        s  = cyc + 1;
        nb = (m == 2'b10 && BURST_EN != 0) ? BL : 1;
        exp_gnt[s] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            r = s + (b + 1) * (WS + 1);
            exp_rdy[r] = 1'b1;
            if (m == 2'b00 || m == 2'b10) begin
                exp_oe[r]   = 1'b1;
                exp_data[r] = mem_m[8'(a + b)];
            end
        end
        if (m == 2'b01) mem_m[a] = d;
        last_edge = s + nb * (WS + 1);
        for (int k = s + 1; k < last_edge; k++) exp_gnt[k] = 1'b1;
        exp_gnt[last_edge] = req_a;
        last_s  = s;
        aborted = 1'b0;
        req = req_s; start = 1'b1; mode = m; addr = a; data_in = d;
        tick();
        while (cyc + 1 < last_edge) begin
            req     = 1'($urandom);
            start   = 1'($urandom);
            mode    = 2'($urandom);
            addr    = 8'($urandom);
            data_in = 8'($urandom);
            tick();
            if (abort_after > 0 && cyc == s + abort_after * (WS + 1)) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
        end
        req = req_a; start = 1'b0;
        tick();
        owned = req_a;
    endtask

    task automatic txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d, input int abort_after);
        if (!owned) hold(1'b1, $urandom_range(1, 2), 1'b0);
        xact(m, a, d, 1'($urandom), 1'($urandom_range(0, 3) != 0), abort_after);
    endtask

    task automatic driver();
        logic [7:0] wrap_vals [4];
        int         n_exp;
        wrap_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) tick();
        chk("init_gnt", 32'(gnt), 32'd0);
        chk("init_rdy", 32'(rdy), 32'd0);
        chk("init_data_oe", 32'(data_oe), 32'd0);
        chk("init_data_out", 32'(data_out), 32'd0);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        hold(1'b0, 2, 1'b0);

        for (int i = 0; i < 256; i++) txn(2'b01, 8'(i), 8'($urandom), 0);
        hold(1'b0, 2, 1'b0);
        #1 do_reset();

        // Write then read with one wait state
        rdy_clear();
        txn(2'b01, 8'h10, 8'hA5, 0);
        n_exp = last_s;
        txn(2'b00, 8'h10, 8'h00, 0);
        #1;
        chk("model_10", 32'(mem_m[8'h10]), 32'hA5);
        chk("wr_rd_pulses", 32'(rdy_c.size()), 32'd2);
        if (rdy_c.size() == 2) begin
            chk("wr_latency", 32'(rdy_c[0] - n_exp), 32'd2);
            chk("rd_latency", 32'(rdy_c[1] - last_s), 32'd2);
            chk("rd_data", 32'(rdy_d[1]), 32'hA5);
            chk("rd_oe", 32'(rdy_oe[1]), 32'd1);
            chk("wr_oe", 32'(rdy_oe[0]), 32'd0);
        end

        // Burst wrap across FF -> 00
        txn(2'b01, 8'hFE, 8'h11, 0);
        txn(2'b01, 8'hFF, 8'h22, 0);
        txn(2'b01, 8'h00, 8'h33, 0);
        txn(2'b01, 8'h01, 8'h44, 0);
        rdy_clear();
        txn(2'b10, 8'hFE, 8'h00, 0);
        #1;
        n_exp = (BURST_EN != 0) ? 4 : 1;
        chk("burst_pulses", 32'(rdy_d.size()), 32'(n_exp));
        for (int i = 0; i < rdy_d.size() && i < 4; i++) chk("burst_data", 32'(rdy_d[i]), 32'(wrap_vals[i]));

        // Ownership release and start while not granted
        hold(1'b1, 2, 1'b0);
        hold(1'b0, 1, 1'b0);
        #1 chk("release_gnt", 32'(gnt), 32'd0);
        rdy_clear();
        hold(1'b0, 10, 1'b1);
        #1 chk("ignored_start", 32'(rdy_d.size()), 32'd0);

        // Reset in the middle of a burst
        rdy_clear();
        txn(2'b10, 8'hFE, 8'h00, 2);
        if (!aborted) begin
            #1 do_reset();
        end
        n_exp = (BURST_EN != 0) ? 2 : 1;
        chk("abort_pulses", 32'(rdy_d.size()), 32'(n_exp));
        rdy_clear();
        txn(2'b00, 8'hFE, 8'h00, 0);
        txn(2'b00, 8'h01, 8'h00, 0);
        #1;
        chk("post_rst_pulses", 32'(rdy_d.size()), 32'd2);
        if (rdy_d.size() == 2) begin
            chk("post_rst_fe", 32'(rdy_d[0]), 32'h11);
            chk("post_rst_01", 32'(rdy_d[1]), 32'h44);
        end

        // NOP leaves memory alone
        rdy_clear();
        txn(2'b11, 8'h10, 8'h5A, 0);
        #1;
        chk("nop_pulses", 32'(rdy_d.size()), 32'd1);
        if (rdy_d.size() == 1) chk("nop_oe", 32'(rdy_oe[0]), 32'd0);
        rdy_clear();
        txn(2'b00, 8'h10, 8'h00, 0);
        #1;
        chk("nop_then_read", 32'(rdy_d.size()), 32'd1);
        if (rdy_d.size() == 1) chk("nop_read_data", 32'(rdy_d[0]), 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int         sel;
            logic [1:0] m;
            sel = $urandom_range(0, 99);
            m   = 2'($urandom);
            if (sel < 70) begin
                txn(m, 8'($urandom), 8'($urandom), 0);
            end else if (sel < 82) begin
                hold(1'b1, $urandom_range(1, 3), 1'b0);
            end else if (sel < 97) begin
                hold(1'b0, $urandom_range(1, 4), 1'($urandom));
            end else begin
                #1 do_reset();
            end
        end
        hold(1'b0, 3, 1'b0);
        done = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        start   = 1'b0;
        mode    = 2'b00;
        addr    = 8'h00;
        data_in = 8'h00;
        fork
            mon();
            driver();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
